// File: rtl/pll_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_pkg
// Description : Shared state encoding and default cycle counts for the PLL
//               reset/bring-up sequencer and the CPU top level.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_reset_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_CORE_UP   = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    localparam int unsigned C_DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned C_DEF_HOLD_CYCLES        = 16;
    localparam int unsigned C_DEF_PERIPH_DELAY       = 8;
    localparam int unsigned C_DEF_TICK_DIV           = 1000;
    localparam int unsigned C_DEF_CNT_W              = 16;

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned v);
        int unsigned w;
        w = $clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff2.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff2
// Description : Two-flop synchronizer for asynchronous level inputs, reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_seq
// Description : Staged core/peripheral reset release after qualified PLL lock,
//               with RUN-state timebase tick and sticky lock-loss flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = C_DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES        = C_DEF_HOLD_CYCLES,
    parameter int unsigned PERIPH_DELAY       = C_DEF_PERIPH_DELAY,
    parameter int unsigned TICK_DIV           = C_DEF_TICK_DIV,
    parameter int unsigned CNT_W              = C_DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       lost_clr,
    output logic       core_rst,
    output logic       periph_rst,
    output logic       ready,
    output logic       tick,
    output logic       lock_lost,
    output logic [2:0] state_dbg
);

    localparam int unsigned TICK_W = cnt_width(TICK_DIV);

    localparam logic [CNT_W-1:0]  C_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  C_HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  C_PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);
    localparam logic [TICK_W-1:0] C_TICK_LAST   = TICK_W'(TICK_DIV - 1);

    logic lock_s;

    state_e            state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [TICK_W-1:0] tick_cnt_q,   tick_cnt_d;
    logic              core_rst_q,   core_rst_d;
    logic              periph_rst_q, periph_rst_d;
    logic              ready_q,      ready_d;
    logic              tick_q,       tick_d;
    logic              lock_lost_q,  lock_lost_d;

    sync_ff2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_lock),
        .q_o (lock_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            tick_cnt_q   <= '0;
            core_rst_q   <= 1'b1;
            periph_rst_q <= 1'b1;
            ready_q      <= 1'b0;
            tick_q       <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            core_rst_q   <= core_rst_d;
            periph_rst_q <= periph_rst_d;
            ready_q      <= ready_d;
            tick_q       <= tick_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tick_cnt_d   = tick_cnt_q;
        core_rst_d   = core_rst_q;
        periph_rst_d = periph_rst_q;
        ready_d      = ready_q;
        tick_d       = 1'b0;
        lock_lost_d  = lock_lost_q;

        if (lost_clr) begin
            lock_lost_d = 1'b0;
        end

        // Lock loss outranks every counter terminal condition; a set also
        // outranks a simultaneous lost_clr because it is applied afterwards.
        if ((state_q != ST_WAIT_LOCK) && !lock_s) begin
            state_d      = ST_WAIT_LOCK;
            cnt_d        = '0;
            tick_cnt_d   = '0;
            core_rst_d   = 1'b1;
            periph_rst_d = 1'b1;
            ready_d      = 1'b0;
            if ((state_q == ST_CORE_UP) || (state_q == ST_RUN)) begin
                lock_lost_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    core_rst_d   = 1'b1;
                    periph_rst_d = 1'b1;
                    ready_d      = 1'b0;
                    cnt_d        = '0;
                    tick_cnt_d   = '0;
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end
                end
                ST_STABLE: begin
                    if (cnt_q == C_STABLE_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == C_HOLD_LAST) begin
                        state_d    = ST_CORE_UP;
                        cnt_d      = '0;
                        core_rst_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_CORE_UP: begin
                    if (cnt_q == C_PERIPH_LAST) begin
                        state_d      = ST_RUN;
                        cnt_d        = '0;
                        periph_rst_d = 1'b0;
                        ready_d      = 1'b1;
                        tick_cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (tick_cnt_q == C_TICK_LAST) begin
                        tick_d     = 1'b1;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                default: begin
                    state_d      = ST_WAIT_LOCK;
                    cnt_d        = '0;
                    tick_cnt_d   = '0;
                    core_rst_d   = 1'b1;
                    periph_rst_d = 1'b1;
                    ready_d      = 1'b0;
                end
            endcase
        end
    end

    assign core_rst   = core_rst_q;
    assign periph_rst = periph_rst_q;
    assign ready      = ready_q;
    assign tick       = tick_q;
    assign lock_lost  = lock_lost_q;
    assign state_dbg  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_seq
// Description : Scoreboard bench for pll_reset_seq with small cycle counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_seq;

    localparam int L = 4;
    localparam int H = 3;
    localparam int P = 2;
    localparam int T = 5;

    localparam logic [7:0] C_RST_V  = 8'b000_1_1_0_0_0;
    localparam logic [7:0] C_LOST_V = 8'b000_1_1_0_0_1;

    typedef struct {
        int         edge_n;
        string      tag;
        logic [7:0] val;
    } sb_t;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       lost_clr;
    logic       core_rst;
    logic       periph_rst;
    logic       ready;
    logic       tick;
    logic       lock_lost;
    logic [2:0] state_dbg;
    logic [7:0] obs;

    sb_t sb[$];
    int  ecnt   = 0;
    int  e0_abs = 0;
    int  n_total = 0;
    int  n_bad   = 0;

    pll_reset_seq #(
        .LOCK_STABLE_CYCLES (L),
        .HOLD_CYCLES        (H),
        .PERIPH_DELAY       (P),
        .TICK_DIV           (T),
        .CNT_W              (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_lock   (pll_lock),
        .lost_clr   (lost_clr),
        .core_rst   (core_rst),
        .periph_rst (periph_rst),
        .ready      (ready),
        .tick       (tick),
        .lock_lost  (lock_lost),
        .state_dbg  (state_dbg)
    );

    assign obs = {state_dbg, core_rst, periph_rst, ready, tick, lock_lost};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%b exp=%b (edge %0d)", tag, got, exp, ecnt);
        end
    endtask

    // Expected outputs k edges after E0 with lock held high since E0.
    function automatic logic [7:0] exp_vec(input int k, input logic lost);
        logic [2:0] st;
        logic       rd;
        logic       tk;
        int         run_at;
        run_at = 2 + L + H + P;
        if (k < 2)              st = 3'd0;
        else if (k < 2 + L)     st = 3'd1;
        else if (k < 2 + L + H) st = 3'd2;
        else if (k < run_at)    st = 3'd3;
        else                    st = 3'd4;
        rd = (k >= run_at);
        tk = (k > run_at) && (((k - run_at) % T) == 0);
        return {st, (k < 2 + L + H), !rd, rd, tk, lost};
    endfunction

    task automatic push(input int e, input string tag, input logic [7:0] v);
        sb_t s;
        s.edge_n = e;
        s.tag    = tag;
        s.val    = v;
        sb.push_back(s);
    endtask

    task automatic push_tl(input int e, input string tag, input logic lost);
        push(e, tag, exp_vec(e - e0_abs, lost));
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            while (sb.size() > 0 && sb[0].edge_n <= ecnt) begin
                sb_t s;
                s = sb.pop_front();
                if (s.edge_n < ecnt)
                    chk("sb_late", 8'(s.edge_n), 8'(ecnt));
                else
                    chk(s.tag, obs, s.val);
            end
            if (periph_rst === 1'b1)
                chk("rdy_tick_in_prst", {6'b0, ready, tick}, 8'h00);
        end
    end

    // Called on a negedge: rst rises and outputs are checked with no edge between.
    task automatic do_reset();
        pll_lock = 1'b0;
        lost_clr = 1'b0;
        #1 rst = 1'b1;
        #1 chk("rst_async", obs, C_RST_V);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bringup(input logic lost, input int n, input string tag);
        pll_lock = 1'b1;
        e0_abs   = ecnt + 1;
        for (int k = 0; k < n; k++) push_tl(e0_abs + k, tag, lost);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int f0;
        rst      = 1'b1;
        pll_lock = 1'b0;
        lost_clr = 1'b0;
        @(negedge clk);

        // Normal bring-up after an idle period with lock low
        do_reset();
        for (int i = 1; i <= 3; i++) push(ecnt + i, "idle_wait", C_RST_V);
        repeat (3) @(negedge clk);
        bringup(1'b0, 27, "bringup");

        // Lock loss while in RUN, then relock
        pll_lock = 1'b0;
        f0 = ecnt + 1;
        push_tl(f0,     "run_loss_f0", 1'b0);
        push_tl(f0 + 1, "run_loss_f1", 1'b0);
        push(f0 + 2, "run_loss_f2", C_LOST_V);
        push(f0 + 3, "run_loss_f3", C_LOST_V);
        push(f0 + 4, "run_loss_f4", C_LOST_V);
        repeat (5) @(negedge clk);
        bringup(1'b1, 27, "relock");

        // lost_clr alone, then clear coinciding with a new set
        lost_clr = 1'b1;
        push_tl(ecnt + 1, "clr_alone", 1'b0);
        @(negedge clk);
        lost_clr = 1'b0;
        pll_lock = 1'b0;
        f0 = ecnt + 1;
        push_tl(f0,     "clrset_f0", 1'b0);
        push_tl(f0 + 1, "clrset_f1", 1'b0);
        push(f0 + 2, "clr_vs_set", C_LOST_V);
        push(f0 + 3, "lost_sticky", C_LOST_V);
        push(f0 + 4, "clr_later", C_RST_V);
        @(negedge clk);
        @(negedge clk);
        lost_clr = 1'b1;
        @(negedge clk);
        lost_clr = 1'b0;
        @(negedge clk);
        lost_clr = 1'b1;
        @(negedge clk);
        lost_clr = 1'b0;

        // Two-cycle lock glitch seen during STABLE
        do_reset();
        pll_lock = 1'b1;
        f0 = ecnt + 1;
        e0_abs = f0;
        for (int k = 0; k < 4; k++) push_tl(f0 + k, "glitch_pre", 1'b0);
        e0_abs = f0 + 4;
        for (int j = 0; j < 23; j++) push_tl(f0 + 4 + j, "glitch_post", 1'b0);
        for (int i = 0; i < 27; i++) begin
            pll_lock = (i == 2 || i == 3) ? 1'b0 : 1'b1;
            @(negedge clk);
        end

        // Asynchronous reset in the middle of HOLD
        do_reset();
        bringup(1'b0, 8, "to_hold");
        #1 rst = 1'b1;
        #1 chk("rst_mid_hold", obs, C_RST_V);
        @(negedge clk);
        chk("rst_held", obs, C_RST_V);
        @(negedge clk);
        rst = 1'b0;
        bringup(1'b0, 13, "restart");

        repeat (2) @(negedge clk);
        chk("sb_drain", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
Reset/bring-up sequencer directly downstream of the GW1NR-9 rPLL wrapper. It runs on the PLL clkout and consumes the PLL LOCK signal. It releases a staged system reset: the CPU core first, then the peripherals, only after lock has been stable for a programmed time. It also produces a periodic timebase tick and flags any lock loss after bring-up.

Parameters:
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before reset release starts (>=1)
HOLD_CYCLES, 16, cycles core reset is held after lock is qualified (>=1)
PERIPH_DELAY, 8, cycles between core reset release and peripheral reset release (>=1)
TICK_DIV, 1000, tick period in clk cycles (>=2)
CNT_W, 16, width of the shared stage counter; must hold max(LOCK_STABLE_CYCLES, HOLD_CYCLES, PERIPH_DELAY)-1

Ports:
clk  in  1  PLL clkout domain clock
rst  in  1  asynchronous active-high reset (board button / POR)
pll_lock  in  1  rPLL LOCK, asynchronous to clk
lost_clr  in  1  synchronous clear of lock_lost
core_rst  out  1  active-high CPU core reset, registered
periph_rst  out  1  active-high peripheral reset, registered
ready  out  1  high only in RUN
tick  out  1  one-cycle strobe every TICK_DIV cycles in RUN
lock_lost  out  1  sticky: lock dropped while in CORE_UP or RUN
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - state = WAIT_LOCK
  - core_rst = 1, periph_rst = 1
  - ready = 0, tick = 0, lock_lost = 0
  - synchronizer flops and all counters = 0
- pll_lock passes through a 2-flop synchronizer to give lock_s, adding 2 edges of latency. All FSM decisions use lock_s.
- States: WAIT_LOCK=0, STABLE=1, HOLD=2, CORE_UP=3, RUN=4. All outputs are registered and change on the transition edge.
- WAIT_LOCK: core_rst=1, periph_rst=1. On lock_s=1: go to STABLE, cnt=0.
- STABLE: if cnt==LOCK_STABLE_CYCLES-1, go to HOLD with cnt=0; otherwise cnt++.
- HOLD: if cnt==HOLD_CYCLES-1, go to CORE_UP, cnt=0, core_rst<=0; otherwise cnt++.
- CORE_UP: if cnt==PERIPH_DELAY-1, go to RUN, periph_rst<=0, ready<=1, tick counter=0; otherwise cnt++.
- RUN: tick counter increments each cycle. At TICK_DIV-1 it sets tick<=1 and wraps to 0; otherwise tick<=0. The first tick is registered TICK_DIV edges after entering RUN.
- Lock drop: lock_s=0 in any state other than WAIT_LOCK takes effect on the next edge:
  - state goes to WAIT_LOCK
  - core_rst<=1, periph_rst<=1, ready<=0, tick<=0, counters cleared
  - if leaving CORE_UP or RUN, lock_lost<=1
  - lock_s=0 has priority over any counter terminal condition on the same edge.
- Timing, with E0 = first edge that samples pll_lock=1 while in WAIT_LOCK:
  - core_rst falls at E(2+LOCK_STABLE_CYCLES+HOLD_CYCLES)
  - periph_rst and ready change at E(2+LOCK_STABLE_CYCLES+HOLD_CYCLES+PERIPH_DELAY)
- lost_clr clears lock_lost. If lost_clr and a new lock-loss set occur on the same edge, set wins.
- A lock glitch shorter than 1 cycle may be missed; this is acceptable.
- A lock glitch seen as lock_s=0 during STABLE restarts qualification from WAIT_LOCK.
- rst asserted mid-sequence returns everything to reset values immediately (asynchronously).
- tick and ready are never high while periph_rst=1.

Decomposition:
- Shared package pll_reset_pkg holds the state encoding constants (3-bit) and the default cycle-count constants; the CPU top-level uses the same constants.
- One sub-module, sync_ff2: a 2-flop synchronizer with async active-high reset to 0, reused for other async inputs.
- The FSM, stage counter and tick counter stay in pll_reset_seq.

Test Plan:
All scenarios use LOCK_STABLE_CYCLES=4, HOLD_CYCLES=3, PERIPH_DELAY=2, TICK_DIV=5.
1. Normal bring-up: rst pulse, then pll_lock=1 from E0 -> core_rst falls at E9, periph_rst falls and ready rises at E11, tick high at E16, E21, E26.
2. Early glitch: pll_lock low for 2 cycles sampled during STABLE -> state returns to WAIT_LOCK, core_rst stays 1 throughout. Release occurs 9 edges after lock is resampled high; lock_lost stays 0.
3. Loss in RUN: pll_lock drops, sampled at F0 -> at F2 core_rst=1, periph_rst=1, ready=0, tick=0, lock_lost=1, state_dbg=0. Relock repeats the timing of scenario 1.
4. Clear vs set: lost_clr on the same edge as a lock-loss set -> lock_lost=1. lost_clr alone later -> lock_lost=0 on the next edge.
5. Async reset mid-HOLD: rst asserted between edges -> all outputs reach reset values without a clock edge. After rst falls with lock held high, the full sequence restarts (core_rst falls 9 edges after the first sampling edge).
